// File: rtl/lpc_pkg.sv
// Shared LPC definitions: cycle type/direction codes, SYNC codes and host FSM encoding.
// Used by both the LPC host and the passive sniffer.
package lpc_pkg;

  localparam logic [3:0] CT_IO_RD  = 4'b0000;
  localparam logic [3:0] CT_IO_WR  = 4'b0010;
  localparam logic [3:0] CT_MEM_RD = 4'b0100;
  localparam logic [3:0] CT_MEM_WR = 4'b0110;

  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;
  localparam logic [3:0] SYNC_NONE       = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_CYCDIR = 4'd2,
    ST_ADDR   = 4'd3,
    ST_WDATA  = 4'd4,
    ST_TAR_H  = 4'd5,
    ST_TAR_Z  = 4'd6,
    ST_SYNC   = 4'd7,
    ST_RDATA  = 4'd8,
    ST_TAR_P  = 4'd9,
    ST_DONE   = 4'd10,
    ST_ABORT  = 4'd11
  } host_state_t;

  // Only the I/O (00) and memory (01) spaces are carried on the bus.
  function automatic logic space_supported(input logic [1:0] space);
    return (space == 2'b00) || (space == 2'b01);
  endfunction

endpackage

// File: rtl/lpc_host.sv
// LPC 1.1 host: turns single-byte I/O and memory requests into LAD/LFRAME# bus cycles
// and returns exactly one response per accepted request.
module lpc_host
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT  = 8,
  parameter int LONG_WAIT_MAX = 1023
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

  localparam int NW = $clog2(SYNC_TIMEOUT + 1);
  localparam int WW = $clog2(LONG_WAIT_MAX + 1);

  host_state_t   state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [NW-1:0] none_q, none_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;

  logic          frame_q, frame_d;
  logic [3:0]    ad_q, ad_d;
  logic          oe_q, oe_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_error_q, rsp_error_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic last_addr;
  logic sync_bad;

  assign accept    = req_valid & ready_q;
  assign last_addr = (cnt_q == (cyc_q[2] ? 3'd7 : 3'd3));
  assign sync_bad  = !(lpc_ad_in inside {SYNC_READY, SYNC_SHORT_WAIT, SYNC_LONG_WAIT, SYNC_NONE});

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = space_supported(req_cyctype_dir[3:2]) ? ST_START : ST_DONE;
      ST_START:  state_d = ST_CYCDIR;
      ST_CYCDIR: state_d = ST_ADDR;
      ST_ADDR:   if (last_addr) state_d = cyc_q[1] ? ST_WDATA : ST_TAR_H;
      ST_WDATA:  if (cnt_q == 3'd1) state_d = ST_TAR_H;
      ST_TAR_H:  state_d = ST_TAR_Z;
      ST_TAR_Z:  state_d = ST_SYNC;
      ST_SYNC: begin
        case (lpc_ad_in)
          SYNC_NONE:
            if (none_q == NW'(SYNC_TIMEOUT - 1)) state_d = ST_ABORT;
          SYNC_SHORT_WAIT, SYNC_LONG_WAIT:
            if (wait_q == WW'(LONG_WAIT_MAX - 1)) state_d = ST_ABORT;
          // Ready and error codes both complete the data phase.
          default: state_d = cyc_q[1] ? ST_TAR_P : ST_RDATA;
        endcase
      end
      ST_RDATA:  if (cnt_q == 3'd1) state_d = ST_TAR_P;
      ST_TAR_P:  if (cnt_q == 3'd1) state_d = ST_DONE;
      ST_ABORT:  if (cnt_q == 3'd3) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
    none_d  = '0;
    wait_d  = '0;
    err_d   = err_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    // A 1111 clears the wait run so later waits start a fresh long count.
    if (state_q == ST_SYNC) begin
      if (lpc_ad_in == SYNC_NONE) begin
        none_d = none_q + NW'(1);
      end else if (lpc_ad_in == SYNC_SHORT_WAIT || lpc_ad_in == SYNC_LONG_WAIT) begin
        none_d = none_q;
        wait_d = wait_q + WW'(1);
      end
    end
    if (accept) begin
      err_d   = !space_supported(req_cyctype_dir[3:2]);
      cyc_d   = req_cyctype_dir;
      addr_d  = req_cyctype_dir[2] ? req_addr : {req_addr[15:0], 16'h0000};
      wdata_d = req_wdata;
      rdata_d = 8'h00;
    end else if (state_q == ST_SYNC && sync_bad) begin
      err_d = 1'b1;
    end else if (state_q == ST_ABORT) begin
      err_d = 1'b1;
    end
    if (state_q == ST_ADDR)  addr_d  = {addr_q[27:0], 4'h0};
    if (state_q == ST_WDATA) wdata_d = {4'h0, wdata_q[7:4]};
    if (state_q == ST_RDATA) rdata_d = (cnt_q == 3'd0) ? {rdata_q[7:4], lpc_ad_in}
                                                       : {lpc_ad_in, rdata_q[3:0]};
  end

  // Outputs are registered from the next state so pins line up with the state they belong to.
  always_comb begin
    frame_d     = 1'b1;
    oe_d        = 1'b0;
    ad_d        = 4'hF;
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    rsp_error_d = (state_d == ST_DONE) && err_d;
    rsp_rdata_d = rsp_rdata_q;
    case (state_d)
      ST_START:  begin frame_d = 1'b0; oe_d = 1'b1; ad_d = 4'h0; end
      ST_CYCDIR: begin oe_d = 1'b1; ad_d = cyc_d; end
      ST_ADDR:   begin oe_d = 1'b1; ad_d = addr_d[31:28]; end
      ST_WDATA:  begin oe_d = 1'b1; ad_d = wdata_d[3:0]; end
      ST_TAR_H:  oe_d = 1'b1;
      ST_ABORT:  begin frame_d = 1'b0; oe_d = 1'b1; end
      ST_DONE:   rsp_rdata_d = err_d ? 8'h00 : rdata_d;
      default:   ;
    endcase
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      cnt_q       <= 3'd0;
      none_q      <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      frame_q     <= 1'b1;
      ad_q        <= 4'hF;
      oe_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      none_q      <= none_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      ad_q        <= ad_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge lpc_clock) begin
    cyc_q   <= cyc_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign lpc_frame  = frame_q;
  assign lpc_ad_out = ad_q;
  assign lpc_ad_oe  = oe_q;

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: directed bus scenarios plus randomized requests, each compared
// cycle by cycle against a bus-level model of the LPC host transaction.
`timescale 1ns/1ps
module tb_lpc_host;

  localparam int SYNC_TIMEOUT  = 8;
  localparam int LONG_WAIT_MAX = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in = 4'hF;

  lpc_host #(.SYNC_TIMEOUT(SYNC_TIMEOUT), .LONG_WAIT_MAX(LONG_WAIT_MAX)) dut (
    .lpc_clock       (clk),
    .lpc_reset       (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_cyctype_dir (req_cyctype_dir),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .lpc_frame       (lpc_frame),
    .lpc_ad_out      (lpc_ad_out),
    .lpc_ad_oe       (lpc_ad_oe),
    .lpc_ad_in       (lpc_ad_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       frame;
    logic       oe;
    logic [3:0] ad;
    logic       rv;
  } bus_t;

  bus_t       exp_q[$];
  logic [3:0] din_q[$];
  logic [3:0] sync_q[$];
  logic       exp_err;
  logic [7:0] exp_rdata;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(15, 0));
  endfunction

  function automatic void push(input logic f, input logic oe, input logic [3:0] ad,
                               input logic rv, input logic [3:0] din);
    bus_t b;
    b.frame = f; b.oe = oe; b.ad = ad; b.rv = rv;
    exp_q.push_back(b);
    din_q.push_back(din);
  endfunction

  // Expected per-cycle bus picture and device drive, built from the LPC transaction rules.
  task automatic build(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] wd,
                       input logic [7:0] dd);
    int         n, nones, waits;
    logic       wr, abort, done;
    logic [31:0] aa;
    logic [3:0] code;
    exp_q.delete();
    din_q.delete();
    exp_err   = 1'b0;
    exp_rdata = 8'h00;
    if (ct[3]) begin
      push(1'b1, 1'b0, 4'hF, 1'b1, rnd4());
      exp_err = 1'b1;
      return;
    end
    wr = ct[1];
    n  = ct[2] ? 8 : 4;
    aa = ct[2] ? a : {16'h0000, a[15:0]};
    push(1'b0, 1'b1, 4'h0, 1'b0, rnd4());
    push(1'b1, 1'b1, ct, 1'b0, rnd4());
    for (int i = n - 1; i >= 0; i--) push(1'b1, 1'b1, aa[4*i +: 4], 1'b0, rnd4());
    if (wr) begin
      push(1'b1, 1'b1, wd[3:0], 1'b0, rnd4());
      push(1'b1, 1'b1, wd[7:4], 1'b0, rnd4());
    end
    push(1'b1, 1'b1, 4'hF, 1'b0, rnd4());
    push(1'b1, 1'b0, 4'hF, 1'b0, rnd4());
    nones = 0; waits = 0; abort = 1'b0; done = 1'b0;
    while (!done && !abort) begin
      code = (sync_q.size() > 0) ? sync_q.pop_front() : 4'h0;
      push(1'b1, 1'b0, 4'hF, 1'b0, code);
      if (code == 4'hF) begin
        nones++; waits = 0;
        abort = (nones >= SYNC_TIMEOUT);
      end else if (code == 4'h5 || code == 4'h6) begin
        waits++;
        abort = (waits >= LONG_WAIT_MAX);
      end else begin
        done    = 1'b1;
        exp_err = (code != 4'h0);
      end
    end
    if (abort) begin
      repeat (4) push(1'b0, 1'b1, 4'hF, 1'b0, rnd4());
      exp_err = 1'b1;
    end else begin
      if (!wr) begin
        push(1'b1, 1'b0, 4'hF, 1'b0, dd[3:0]);
        push(1'b1, 1'b0, 4'hF, 1'b0, dd[7:4]);
        if (!exp_err) exp_rdata = dd;
      end
      push(1'b1, 1'b0, 4'hF, 1'b0, rnd4());
      push(1'b1, 1'b0, 4'hF, 1'b0, rnd4());
    end
    push(1'b1, 1'b0, 4'hF, 1'b1, rnd4());
  endtask

  task automatic run_txn(input string tag, input logic [3:0] ct, input logic [31:0] a,
                         input logic [7:0] wd, input logic [7:0] dd);
    build(ct, a, wd, dd);
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_cyctype_dir = ct; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_cyctype_dir = rnd4(); req_addr = $urandom; req_wdata = 8'($urandom);
    for (int c = 0; c < exp_q.size(); c++) begin
      req_valid = (c < exp_q.size() - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      lpc_ad_in = din_q[c];
      @(negedge clk);
      chk($sformatf("%s c%0d frame", tag, c + 1), 32'(lpc_frame), 32'(exp_q[c].frame));
      chk($sformatf("%s c%0d oe", tag, c + 1), 32'(lpc_ad_oe), 32'(exp_q[c].oe));
      if (exp_q[c].oe) chk($sformatf("%s c%0d lad", tag, c + 1), 32'(lpc_ad_out), 32'(exp_q[c].ad));
      chk($sformatf("%s c%0d rsp_valid", tag, c + 1), 32'(rsp_valid), 32'(exp_q[c].rv));
      chk($sformatf("%s c%0d ready_busy", tag, c + 1), 32'(req_ready), 32'd0);
      if (exp_q[c].rv) begin
        chk({tag, " rsp_error"}, 32'(rsp_error), 32'(exp_err));
        chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
      end
      @(posedge clk); #1;
    end
    lpc_ad_in = rnd4();
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rdata_held"}, 32'(rsp_rdata), 32'(exp_rdata));
    chk({tag, " frame_after"}, 32'(lpc_frame), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " frame"}, 32'(lpc_frame), 32'd1);
    chk({tag, " oe"}, 32'(lpc_ad_oe), 32'd0);
    chk({tag, " lad"}, 32'(lpc_ad_out), 32'hF);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, " rsp_error"}, 32'(rsp_error), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    sync_q = '{4'h0};
    run_txn("io_wr", 4'h2, 32'h0000_0080, 8'hA5, 8'h00);
    sync_q = '{4'h6, 4'h6, 4'h6, 4'h0};
    run_txn("io_rd", 4'h0, 32'h0000_03F8, 8'h00, 8'hC5);
    sync_q = '{4'h0};
    run_txn("mem_rd", 4'h4, 32'hFFFF_FFF0, 8'h00, 8'h12);
    sync_q.delete();
    repeat (SYNC_TIMEOUT) sync_q.push_back(4'hF);
    run_txn("no_dev", 4'h0, 32'h0000_0060, 8'h00, 8'h3C);
    sync_q = '{4'hA};
    run_txn("sync_err", 4'h0, 32'h0000_0064, 8'h00, 8'h77);
    sync_q.delete();
    run_txn("bad_type", 4'h8, 32'h1234_5678, 8'h55, 8'h00);
    sync_q = '{4'h5, 4'hF, 4'h6, 4'h0};
    run_txn("mem_wr", 4'h6, 32'hDEAD_BEEF, 8'h3C, 8'h00);
    sync_q.delete();
    repeat (LONG_WAIT_MAX) sync_q.push_back(4'h5);
    run_txn("long_wait", 4'h0, 32'h0000_0070, 8'h00, 8'h99);

    // Reset in the middle of the address phase drops the request silently.
    @(negedge clk);
    req_valid = 1'b1; req_cyctype_dir = 4'h2; req_addr = 32'h0000_1234; req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst pre oe", 32'(lpc_ad_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst held rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    sync_q = '{4'h0};
    run_txn("after_rst", 4'h0, 32'h0000_02F8, 8'h00, 8'h6B);

    for (int t = 0; t < 24; t++) begin
      logic [3:0] ct;
      int         kind;
      int         len;
      kind = $urandom_range(9, 0);
      ct = (kind == 0) ? 4'($urandom_range(15, 8))
                       : {1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0};
      sync_q.delete();
      if (kind == 1) begin
        repeat (SYNC_TIMEOUT + 2) sync_q.push_back(4'hF);
      end else begin
        len = $urandom_range(6, 0);
        repeat (len) begin
          case ($urandom_range(2, 0))
            0:       sync_q.push_back(4'h5);
            1:       sync_q.push_back(4'h6);
            default: sync_q.push_back(4'hF);
          endcase
        end
        case ($urandom_range(4, 0))
          0:       sync_q.push_back(4'hA);
          1:       sync_q.push_back(4'h3);
          default: sync_q.push_back(4'h0);
        endcase
      end
      run_txn($sformatf("rnd%0d", t), ct, $urandom, 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
